serial_subtractor: RTL and testbench

- Multi-cycle, bit-serial two's-complement subtractor computing A − B.
- Processes one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow; this is the inverse-direction counterpart of the team's ripple full-adder datapath.
- Used in the ALU slow path and by the upcoming restoring divider as its subtract step.
- start/busy/done handshake to the controlling FSM.

---
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement A-B, LSB first; SERIAL_SUB_ADD_MODE_EN adds op port for A+B
module serial_subtractor #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic         op,
`endif
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out,
  output logic         ovf,
  output logic         err
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   sa;
  logic [N-1:0]   sb;
  logic [N-1:0]   res;
  logic [CW-1:0]  cnt;
  logic           bin;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic           op_r;
`endif

  logic x, y, d, bnext, ovf_next;

  // One full-subtractor (or full-adder in add mode) cell on the current LSBs.
  // On the final step x and y are the operand sign bits, so overflow is
  // derived from them directly instead of keeping copies of a and b.
  always_comb begin
    x        = sa[0];
    y        = sb[0];
    d        = x ^ y ^ bin;
    bnext    = (~x & y) | (~x & bin) | (y & bin);
    ovf_next = (x != y) && (d != x);
`ifdef SERIAL_SUB_ADD_MODE_EN
    if (op_r) begin
      bnext    = (x & y) | (x & bin) | (y & bin);
      ovf_next = (x == y) && (d != x);
    end
`endif
  end

  // Control FSM plus datapath; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      cnt        <= '0;
      bin        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
      err        <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      op_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            res   <= '0;
            cnt   <= '0;
            bin   <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SERIAL_SUB_ADD_MODE_EN
            op_r  <= op;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // A start request here is a protocol violation; the operation continues untouched.
          if (start) err <= 1'b1;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= {d, res[N-1:1]};
          bin <= bnext;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= {d, res[N-1:1]};
            borrow_out <= bnext;
            ovf        <= ovf_next;
          end
        end
        default: begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (N=16)
module tb_serial_subtractor;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a_i = '0;
  logic [N-1:0] b_i = '0;
  logic         busy, done, borrow_out, ovf, err;
  logic [N-1:0] diff;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic         op_i = 1'b0;
`endif

  int n_total = 0;
  int n_pass  = 0;

  serial_subtractor #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .op(op_i),
`endif
    .a(a_i),
    .b(b_i),
    .busy(busy),
    .done(done),
    .diff(diff),
    .borrow_out(borrow_out),
    .ovf(ovf),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model_sub(input logic [N-1:0] av, input logic [N-1:0] bv,
                           output logic [N-1:0] ed, output logic eb, output logic eo);
    int sa, sb, r;
    sa = $signed(av);
    sb = $signed(bv);
    r  = sa - sb;
    ed = av - bv;
    eb = (av < bv);
    eo = (r > 32767) || (r < -32768);
  endtask

  // Called at the sample point of cycle T; leaves the bench at cycle T+1.
  task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv);
    a_i   = av;
    b_i   = bv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic [N-1:0] ed,
                        input logic eb, input logic eo, input string nm);
    int bad;
    bad = 0;
    start_op(av, bv);
    for (int k = 0; k < N; k++) begin
      if (!(busy === 1'b1 && done === 1'b0 && err === 1'b0)) bad++;
      step();
    end
    chk({nm, " run busy"}, bad, 0);
    chk({nm, " done"}, {busy, done, err}, 3'b010);
    chk({nm, " diff"}, diff, ed);
    chk({nm, " borrow"}, borrow_out, eb);
    chk({nm, " ovf"}, ovf, eo);
  endtask

  initial begin
    vec_t         tbl[5];
    logic [N-1:0] ra, rb, ed;
    logic         eb, eo;
    int           seen;

    tbl[0] = '{a: 16'h0005, b: 16'h0003, d: 16'h0002, bo: 1'b0, ov: 1'b0};
    tbl[1] = '{a: 16'h0000, b: 16'h0001, d: 16'hFFFF, bo: 1'b1, ov: 1'b0};
    tbl[2] = '{a: 16'h8000, b: 16'h0001, d: 16'h7FFF, bo: 1'b0, ov: 1'b1};
    tbl[3] = '{a: 16'h7FFF, b: 16'hFFFF, d: 16'h8000, bo: 1'b1, ov: 1'b1};
    tbl[4] = '{a: 16'h000A, b: 16'h000A, d: 16'h0000, bo: 1'b0, ov: 1'b0};

    rst = 1'b1;
    step();
    step();
    chk("reset outputs", {busy, done, diff, borrow_out, ovf, err}, '0);
    rst = 1'b0;
    step();

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo, tbl[i].ov, $sformatf("vec%0d", i));
      if (i == 1) begin
        for (int k = 0; k < 5; k++) step();
        chk("hold diff", diff, 16'hFFFF);
        chk("hold flags", {busy, done, borrow_out, ovf, err}, 5'b00100);
      end
    end

    // Start during RUN: err for exactly one cycle, result unaffected.
    start_op(16'h1234, 16'h0034);               // now at T+1
    step(); step(); step();                      // T+4
    chk("err before", err, 1'b0);
    a_i = 16'hFFFF; start = 1'b1;
    step();                                      // T+5
    start = 1'b0;
    chk("err pulse", err, 1'b1);
    step();                                      // T+6
    chk("err cleared", err, 1'b0);
    for (int k = 0; k < 10; k++) step();         // T+16
    chk("no early done", {busy, done}, 2'b10);
    step();                                      // T+17
    chk("err case done", {busy, done}, 2'b01);
    chk("err case diff", diff, 16'h1200);
    // Re-accept in the DONE cycle.
    a_i = 16'h0005; b_i = 16'h0003; start = 1'b1;
    step();                                      // T+18
    start = 1'b0;
    chk("b2b busy", {busy, done, err}, 3'b100);
    for (int k = 0; k < 16; k++) step();         // T+34
    chk("b2b done", {busy, done}, 2'b01);
    chk("b2b diff", diff, 16'h0002);

    // Reset mid-operation.
    start_op(16'h00F0, 16'h0001);                // T+1
    step(); step(); step(); step();              // T+5
    rst = 1'b1;
    step();                                      // T+6
    rst = 1'b0;
    chk("mid rst", {busy, done, diff}, '0);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      if (done === 1'b1) seen++;
      step();
    end
    chk("no done after rst", seen, 0);
    run_op(16'h000A, 16'h000A, 16'h0000, 1'b0, 1'b0, "post rst");

    // Randomized against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if (i == 0) rb = ra;
      if (i == 1) begin ra = 16'h8000; rb = 16'h7FFF; end
      model_sub(ra, rb, ed, eb, eo);
      run_op(ra, rb, ed, eb, eo, $sformatf("rnd%0d", i));
    end

`ifdef SERIAL_SUB_ADD_MODE_EN
    op_i = 1'b1;
    run_op(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, "add ovf");
    run_op(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, "add carry");
    op_i = 1'b0;
    run_op(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, "sub after add");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
